mem_dump_unit: RTL
==================

Name: mem_dump_unit

Overview:
- Halt-detect and data-memory readout block for the RISC-V core.
- Watches the fetched instruction stream; declares the program finished after a run of consecutive NOPs.
- Then reads a fixed window of data memory and streams each word out over a valid/ready interface to a checker or host.
- Sits beside the core: snoops the instruction-memory output and shares the data-memory read port once the core is halted.

Parameters:
- DATA_WIDTH, 32, data-memory word width and output data width
- ADDR_WIDTH, 10, data-memory word-address width
- NOP_WORD, 32'h00000013, instruction encoding treated as NOP (addi x0,x0,0)
- NOP_COUNT, 3, consecutive valid NOPs required to declare halt (≥1)
- BASE_ADDR, 0, first word address dumped
- WORD_COUNT, 16, number of words dumped (≥1, BASE_ADDR+WORD_COUNT ≤ 2^ADDR_WIDTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr_i  in  32  instruction-memory output data
- instr_valid_i  in  1  instr_i is a real fetch this cycle
- mem_rd_en_o  out  1  data-memory read request
- mem_addr_o  out  ADDR_WIDTH  data-memory word address
- mem_rd_data_i  in  DATA_WIDTH  read data, valid one cycle after mem_rd_en_o
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer accepts the word
- out_data_o  out  DATA_WIDTH  dumped word
- out_addr_o  out  ADDR_WIDTH  address of out_data_o
- out_last_o  out  1  final word of the dump
- halted_o  out  1  halt detected (sticky until reset)
- done_o  out  1  dump complete (sticky until reset)

Behaviour:
- Clock/reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: all outputs 0, NOP counter 0, state RUN. Reset asserted in any state aborts immediately; the next cycle is RUN with all outputs 0.
- States: RUN, ISSUE, CAPTURE, PRESENT, DONE.
- RUN:
  - On each cycle with instr_valid_i=1: instr_i==NOP_WORD increments the counter (saturating at NOP_COUNT); any other value clears it.
  - instr_valid_i=0 leaves the counter unchanged.
  - When the counter reaches NOP_COUNT, the next cycle has halted_o=1 and state ISSUE.
  - Halt is declared on the cycle the NOP_COUNT-th NOP is sampled.
- ISSUE:
  - mem_rd_en_o=1, mem_addr_o=current address (starts at BASE_ADDR).
  - Go to CAPTURE.
- CAPTURE:
  - Register mem_rd_data_i into out_data_o and the current address into out_addr_o.
  - out_valid_o=1 from the next cycle.
  - out_last_o=1 when the index equals WORD_COUNT-1.
  - Go to PRESENT.
- PRESENT:
  - out_valid_o, out_data_o, out_addr_o and out_last_o held stable until out_valid_o && out_ready_i.
  - On acceptance of a non-last word: out_valid_o drops next cycle, address increments, state ISSUE.
  - On acceptance of the last word: state DONE.
- DONE:
  - done_o=1, out_valid_o=0, mem_rd_en_o=0.
  - Remains in DONE until reset; instruction activity is ignored.
- Throughput: one word per 3 cycles at minimum (ISSUE, CAPTURE, PRESENT accepted).
- Latency: first out_valid_o rises 3 cycles after the halt-detect cycle.
- mem_rd_en_o is 0 in every state except ISSUE.
- mem_addr_o holds its last value outside ISSUE.
- out_ready_i high while out_valid_o=0 has no effect.
- After halt, instr_i and instr_valid_i are ignored.
- Address arithmetic is ADDR_WIDTH-bit unsigned; the parameter constraint guarantees no wrap.

Optional Feature:
- MEM_DUMP_CHECKSUM_EN defined:
  - A DATA_WIDTH accumulator (wrapping modulo 2^DATA_WIDTH, cleared at reset) sums every accepted data word.
  - After the last data word is accepted, one extra beat is presented with out_data_o=sum, out_addr_o=0 and out_last_o=1.
  - On that beat out_last_o moves from the last data word to the checksum beat.
  - DONE is entered when the checksum beat is accepted.
- MEM_DUMP_CHECKSUM_EN undefined: no accumulator and no extra beat; behaviour as above.

Test Plan:
- Reset then 3 valid NOPs on consecutive cycles → halted_o=1 on the cycle after the 3rd; mem_rd_en_o=1, mem_addr_o=0 that same cycle; out_valid_o rises 3 cycles after the 3rd NOP.
- Sequence NOP, NOP, 32'h00500093, NOP, NOP → no halt; one further NOP → halt.
- NOP, (instr_valid_i=0 ×4), NOP, NOP → halt, since invalid cycles neither count nor clear.
- Memory preloaded with words 16..1 (sorted-descending pattern), out_ready_i tied 1 → 16 beats, data 16..1, addresses 0..15, out_last_o only on address 15, done_o=1 after it.
- out_ready_i low for 5 cycles on beat 4 → out_data_o/out_addr_o stable throughout, no extra mem_rd_en_o pulses, no beat lost or duplicated.
- Reset asserted while PRESENT on beat 7 → next cycle all outputs 0; 3 fresh NOPs restart the dump at address 0. With MEM_DUMP_CHECKSUM_EN and data 1..16 → extra beat 136 carrying out_last_o.

Source files
------------

// File: rtl/mem_dump_unit.sv
// Halt detector and data-memory dumper. It watches the fetch stream for a run of NOPs, then
// reads a fixed window of data memory and streams it out over valid/ready.
// Build option MEM_DUMP_CHECKSUM_EN appends a final beat that carries the wrapping sum of the words.
module mem_dump_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
  parameter int          NOP_COUNT  = 3,
  parameter int          BASE_ADDR  = 0,
  parameter int          WORD_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_i,
  input  logic                  instr_valid_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_last_o,
  output logic                  halted_o,
  output logic                  done_o
);

  localparam int CW = $clog2(NOP_COUNT + 1);
  localparam logic [CW-1:0]         NOP_TARGET = CW'(NOP_COUNT);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + WORD_COUNT - 1);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_SUM     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         nop_cnt_q, nop_cnt_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  halted_q, halted_d;
  logic                  done_q, done_d;
  logic                  is_last_word;
  logic                  accept;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign is_last_word = (cur_addr_q == LAST_ADDR);
  assign accept       = out_valid_q && out_ready_i;

  always_comb begin
    state_d     = state_q;
    nop_cnt_d   = nop_cnt_q;
    cur_addr_d  = cur_addr_q;
    mem_addr_d  = mem_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    halted_d    = halted_q;
    done_d      = done_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_RUN: begin
        if (instr_valid_i) begin
          if (instr_i == NOP_WORD)
            nop_cnt_d = (nop_cnt_q == NOP_TARGET) ? nop_cnt_q : nop_cnt_q + CW'(1);
          else
            nop_cnt_d = '0;
        end
        // Halt takes effect on the edge that samples the final NOP.
        if (nop_cnt_d == NOP_TARGET) begin
          halted_d   = 1'b1;
          mem_addr_d = cur_addr_q;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        out_data_d  = mem_rd_data_i;
        out_addr_d  = cur_addr_q;
        out_valid_d = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = is_last_word;
`endif
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (accept) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          sum_d = sum_q + out_data_q;
`endif
          if (is_last_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            // Stay valid and swap the beat contents for the checksum.
            out_data_d = sum_q + out_data_q;
            out_addr_d = '0;
            out_last_d = 1'b1;
            state_d    = S_SUM;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
`endif
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cur_addr_d  = cur_addr_q + 1'b1;
            mem_addr_d  = cur_addr_q + 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_SUM: begin
        if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      nop_cnt_q   <= '0;
      cur_addr_q  <= FIRST_ADDR;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nop_cnt_q   <= nop_cnt_d;
      cur_addr_q  <= cur_addr_d;
      mem_addr_q  <= mem_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_rd_en_o = (state_q == S_ISSUE);
  assign mem_addr_o  = mem_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign out_last_o  = out_last_q;
  assign halted_o    = halted_q;
  assign done_o      = done_q;

endmodule
